// File: rtl/group_reader.sv
// group_reader
//   Walks a zero-delimited group buffer in the token RAM and streams every
//   stored token out on a valid/ready interface. Each token carries its group
//   index and a flag that marks the last token of its group. Each group is a
//   run of non-zero words closed by a single 0. The list ends at the first
//   group slot that holds 0.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous reset, active high
//   cs         start strobe, honoured only while idle or done
//   base_addr  first buffer address, latched when cs is accepted
//   rd_addr    RAM read address (synchronous RAM, data one cycle later)
//   rd_data    RAM read data
//   out_data   current token
//   out_valid  token valid
//   out_ready  consumer ready; transfer on out_valid & out_ready
//   out_last   token is the last of its group
//   out_group  group index of out_data
//   n_groups   groups emitted so far (final count once done is set)
//   done       list finished, held until the next accepted cs
//   err        address space exhausted before the terminator (valid with done)
module group_reader #(
    parameter int unsigned ADDR_WIDTH      = 4,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned GROUP_CNT_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cs,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    output logic [ADDR_WIDTH-1:0]      rd_addr,
    input  logic [DATA_WIDTH-1:0]      rd_data,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [GROUP_CNT_WIDTH-1:0] out_group,
    output logic [GROUP_CNT_WIDTH-1:0] n_groups,
    output logic                       done,
    output logic                       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]      tok_q, tok_d;
    logic [DATA_WIDTH-1:0]      nxt_q, nxt_d;
    logic                       have_tok_q, have_tok_d;
    logic                       last_q, last_d;
    logic [GROUP_CNT_WIDTH-1:0] grp_q, grp_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       ptr_at_end;

    // The pointer never wraps: stepping past the top address ends the list
    // with an error instead.
    assign ptr_at_end = (ptr_q == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            tok_q      <= '0;
            nxt_q      <= '0;
            have_tok_q <= 1'b0;
            last_q     <= 1'b0;
            grp_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            tok_q      <= tok_d;
            nxt_q      <= nxt_d;
            have_tok_q <= have_tok_d;
            last_q     <= last_d;
            grp_q      <= grp_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        tok_d      = tok_q;
        nxt_d      = nxt_q;
        have_tok_d = have_tok_q;
        last_d     = last_q;
        grp_d      = grp_q;
        done_d     = done_q;
        err_d      = err_q;

        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        out_group  = '0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (cs) begin
                    ptr_d      = base_addr;
                    grp_d      = '0;
                    have_tok_d = 1'b0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    state_d    = S_RD;
                end
            end

            S_RD: begin
                state_d = S_CAP;
            end

            // One-word lookahead: a token is emitted only once the word after
            // it is known, so out_last is available together with the token.
            S_CAP: begin
                if (!have_tok_q) begin
                    if (rd_data == '0) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        tok_d      = rd_data;
                        have_tok_d = 1'b1;
                        if (ptr_at_end) begin
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            ptr_d   = ptr_q + ADDR_WIDTH'(1);
                            state_d = S_RD;
                        end
                    end
                end else begin
                    if (rd_data == '0) begin
                        last_d = 1'b1;
                    end else begin
                        nxt_d  = rd_data;
                        last_d = 1'b0;
                    end
                    state_d = S_EMIT;
                end
            end

            S_EMIT: begin
                out_valid = 1'b1;
                out_data  = tok_q;
                out_last  = last_q;
                out_group = grp_q;
                if (out_ready) begin
                    if (last_q) begin
                        // ptr sits on the separator; stepping once more lands
                        // on the next group's first word.
                        have_tok_d = 1'b0;
                        grp_d      = grp_q + GROUP_CNT_WIDTH'(1);
                    end else begin
                        tok_d = nxt_q;
                    end
                    if (ptr_at_end) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = ptr_q + ADDR_WIDTH'(1);
                        state_d = S_RD;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rd_addr  = ptr_q;
    assign n_groups = grp_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_group_reader.sv
module tb_group_reader;

    localparam int AW     = 4;
    localparam int DW     = 8;
    localparam int GW     = 4;
    localparam int LAST_I = (1 << AW) - 1;
    localparam int BUDGET = 600;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [GW-1:0] out_group;
    logic [GW-1:0] n_groups;
    logic          done;
    logic          err;

    group_reader #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .GROUP_CNT_WIDTH (GW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .base_addr (base_addr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_group (out_group),
        .n_groups  (n_groups),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Synchronous token RAM
    logic [DW-1:0] ram [0:LAST_I];
    always @(posedge clk) rd_data <= ram[rd_addr];

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [GW-1:0] g;
    } tok_t;

    int   checks = 0;
    int   errors = 0;
    tok_t exp_q[$];
    tok_t obs_q[$];
    tok_t c1 [3];
    logic [GW-1:0] exp_ng;
    logic          exp_err;

    // Reference: walk the buffer group by group. A token is known to be last
    // when the following word is 0. Every step to a new address must stay
    // inside the address space, otherwise the walk stops with an error after
    // the token that triggered the step has been transferred.
    function automatic void build_model(input int base);
        int a;
        int i;
        logic [GW-1:0] g;
        tok_t t;
        exp_q.delete();
        g = '0;
        exp_err = 1'b0;
        a = base;
        forever begin
            if (ram[a[AW-1:0]] == '0) break;
            if (a == LAST_I) begin
                exp_err = 1'b1;
                break;
            end
            i = a;
            forever begin
                t.d = ram[i[AW-1:0]];
                t.l = (ram[AW'(i + 1)] == '0);
                t.g = g;
                exp_q.push_back(t);
                if (t.l) g = g + GW'(1);
                if (i + 1 == LAST_I) begin
                    exp_err = 1'b1;
                    break;
                end
                if (t.l) break;
                i++;
            end
            if (exp_err) break;
            a = i + 2;
        end
        exp_ng = g;
    endfunction

    task automatic clear_ram();
        for (int k = 0; k <= LAST_I; k++) ram[k] = '0;
    endtask

    task automatic set_case1();
        clear_ram();
        ram[0] = 8'd5; ram[1] = 8'd7; ram[2] = 8'd0;
        ram[3] = 8'd9; ram[4] = 8'd0; ram[5] = 8'd0;
    endtask

    // Start a list and collect every transferred token into obs_q.
    // Cycle numbers count negedges after the accepting edge (0 = first).
    task automatic run_list(input logic [AW-1:0] base, input int ready_pct,
                            input bit poke_cs, output int first_valid,
                            output int done_at, output int stall_viol);
        tok_t t;
        tok_t held;
        bit   stalled;
        obs_q.delete();
        first_valid = -1;
        done_at     = -1;
        stall_viol  = 0;
        stalled     = 1'b0;
        held        = '0;
        base_addr   = base;
        out_ready   = 1'b0;
        cs          = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        for (int n = 0; n < BUDGET; n++) begin
            if (out_valid && first_valid < 0) first_valid = n;
            if (done) begin
                done_at = n;
                break;
            end
            t.d = out_data;
            t.l = out_last;
            t.g = out_group;
            if (stalled && (!out_valid || t !== held)) stall_viol++;
            out_ready = (int'($urandom_range(99)) < ready_pct);
            cs        = poke_cs && out_valid;
            if (out_valid && out_ready) obs_q.push_back(t);
            stalled = out_valid && !out_ready;
            held    = t;
            @(negedge clk);
        end
        cs        = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cs        = 1'b0;
        out_ready = 1'b0;
        base_addr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_last, out_data, out_group} !== '0) begin
            errors++;
            $display("FAIL reset_stream got v=%0b l=%0b d=%0d g=%0d required all 0",
                     out_valid, out_last, out_data, out_group);
        end
        checks++;
        if ({done, err, n_groups, rd_addr} !== '0) begin
            errors++;
            $display("FAIL reset_status got done=%0b err=%0b ng=%0d addr=%0d required all 0",
                     done, err, n_groups, rd_addr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int fv, da, sv;
        set_case1();
        run_list(4'd0, 100, 1'b0, fv, da, sv);
        checks++;
        if (fv != 4) begin
            errors++;
            $display("FAIL basic_latency got=%0d required=4", fv);
        end
        checks++;
        if (da != 15) begin
            errors++;
            $display("FAIL basic_done_cycle got=%0d required=15", da);
        end
        checks++;
        if (obs_q.size() != 3) begin
            errors++;
            $display("FAIL basic_count got=%0d required=3", obs_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_q[k] !== c1[k]) begin
                    errors++;
                    $display("FAIL basic_tok%0d got=(%0d,%0b,%0d) required=(%0d,%0b,%0d)", k,
                             obs_q[k].d, obs_q[k].l, obs_q[k].g, c1[k].d, c1[k].l, c1[k].g);
                end
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({done, err, n_groups} !== {1'b1, 1'b0, 4'd2}) begin
            errors++;
            $display("FAIL basic_final got done=%0b err=%0b ng=%0d required 1 0 2",
                     done, err, n_groups);
        end
    endtask

    task automatic test_empty();
        int fv, da, sv;
        for (int k = 0; k <= LAST_I; k++) ram[k] = DW'(k + 1);
        ram[3] = '0;
        run_list(4'd3, 100, 1'b0, fv, da, sv);
        checks++;
        if (da != 2) begin
            errors++;
            $display("FAIL empty_done_cycle got=%0d required=2", da);
        end
        checks++;
        if (fv != -1 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL empty_no_valid got first=%0d n=%0d required -1 0", fv, obs_q.size());
        end
        checks++;
        if ({done, err, n_groups} !== {1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL empty_final got done=%0b err=%0b ng=%0d required 1 0 0",
                     done, err, n_groups);
        end
    endtask

    task automatic test_stall();
        int   seen7;
        int   da;
        tok_t t;
        set_case1();
        obs_q.delete();
        seen7     = 0;
        da        = -1;
        base_addr = '0;
        out_ready = 1'b1;
        cs        = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        for (int n = 0; n < BUDGET; n++) begin
            if (done) begin
                da = n;
                break;
            end
            out_ready = 1'b1;
            if (out_valid && out_data == 8'd7) begin
                checks++;
                if (out_last !== 1'b1 || rd_addr !== 4'd2) begin
                    errors++;
                    $display("FAIL stall_hold got last=%0b addr=%0d required 1 2",
                             out_last, rd_addr);
                end
                if (seen7 < 3) out_ready = 1'b0;
                seen7++;
            end
            t.d = out_data;
            t.l = out_last;
            t.g = out_group;
            if (out_valid && out_ready) obs_q.push_back(t);
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (seen7 != 4) begin
            errors++;
            $display("FAIL stall_cycles got=%0d required=4", seen7);
        end
        checks++;
        if (da < 0 || obs_q.size() != 3) begin
            errors++;
            $display("FAIL stall_count got done_at=%0d n=%0d required done and 3", da, obs_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_q[k] !== c1[k]) begin
                    errors++;
                    $display("FAIL stall_tok%0d got=(%0d,%0b,%0d) required=(%0d,%0b,%0d)", k,
                             obs_q[k].d, obs_q[k].l, obs_q[k].g, c1[k].d, c1[k].l, c1[k].g);
                end
            end
        end
        checks++;
        if (n_groups !== 4'd2) begin
            errors++;
            $display("FAIL stall_ngroups got=%0d required=2", n_groups);
        end
    endtask

    task automatic test_wrap();
        int fv, da, sv;
        tok_t w;
        clear_ram();
        ram[14] = 8'd3;
        ram[15] = 8'd4;
        w.d = 8'd3; w.l = 1'b0; w.g = '0;
        run_list(4'd14, 100, 1'b0, fv, da, sv);
        checks++;
        if (da != 5) begin
            errors++;
            $display("FAIL wrap_done_cycle got=%0d required=5", da);
        end
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL wrap_count got=%0d required=1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== w) begin
                errors++;
                $display("FAIL wrap_tok got=(%0d,%0b,%0d) required=(3,0,0)",
                         obs_q[0].d, obs_q[0].l, obs_q[0].g);
            end
        end
        checks++;
        if ({done, err, n_groups} !== {1'b1, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL wrap_final got done=%0b err=%0b ng=%0d required 1 1 0",
                     done, err, n_groups);
        end
    endtask

    task automatic test_reset_mid();
        int  fv, da, sv;
        bit  seen;
        set_case1();
        seen      = 1'b0;
        base_addr = '0;
        out_ready = 1'b0;
        cs        = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rstmid_valid got out_valid=0 required 1 within 20 cycles");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({out_valid, done, n_groups, rd_addr} !== '0) begin
            errors++;
            $display("FAIL rstmid_clear got v=%0b done=%0b ng=%0d addr=%0d required all 0",
                     out_valid, done, n_groups, rd_addr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, done} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_idle got v=%0b done=%0b required 0 0", out_valid, done);
        end
        run_list(4'd0, 100, 1'b0, fv, da, sv);
        checks++;
        if (da < 0 || obs_q.size() != 3) begin
            errors++;
            $display("FAIL rstmid_count got done_at=%0d n=%0d required done and 3", da, obs_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_q[k] !== c1[k]) begin
                    errors++;
                    $display("FAIL rstmid_tok%0d got=(%0d,%0b,%0d) required=(%0d,%0b,%0d)", k,
                             obs_q[k].d, obs_q[k].l, obs_q[k].g, c1[k].d, c1[k].l, c1[k].g);
                end
            end
        end
    endtask

    task automatic test_cs_ignored();
        int fv, da, sv;
        set_case1();
        run_list(4'd0, 60, 1'b1, fv, da, sv);
        checks++;
        if (da < 0 || obs_q.size() != 3) begin
            errors++;
            $display("FAIL csign_count got done_at=%0d n=%0d required done and 3", da, obs_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_q[k] !== c1[k]) begin
                    errors++;
                    $display("FAIL csign_tok%0d got=(%0d,%0b,%0d) required=(%0d,%0b,%0d)", k,
                             obs_q[k].d, obs_q[k].l, obs_q[k].g, c1[k].d, c1[k].l, c1[k].g);
                end
            end
        end
        checks++;
        if ({n_groups, err, sv} !== {4'd2, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL csign_final got ng=%0d err=%0b stall_viol=%0d required 2 0 0",
                     n_groups, err, sv);
        end
    endtask

    task automatic test_random();
        int fv, da, sv, pct;
        logic [AW-1:0] base;
        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k <= LAST_I; k++)
                ram[k] = ($urandom_range(99) < 25) ? '0 : DW'($urandom_range(255, 1));
            base = AW'($urandom_range(LAST_I));
            case (it % 3)
                0:       pct = 100;
                1:       pct = 70;
                default: pct = 30;
            endcase
            build_model(int'(base));
            run_list(base, pct, 1'b0, fv, da, sv);
            checks++;
            if (da < 0 || obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count got done_at=%0d n=%0d required done and %0d",
                         it, da, obs_q.size(), exp_q.size());
            end else begin
                for (int k = 0; k < exp_q.size(); k++) begin
                    checks++;
                    if (obs_q[k] !== exp_q[k]) begin
                        errors++;
                        $display("FAIL rand%0d_tok%0d got=(%0d,%0b,%0d) required=(%0d,%0b,%0d)",
                                 it, k, obs_q[k].d, obs_q[k].l, obs_q[k].g,
                                 exp_q[k].d, exp_q[k].l, exp_q[k].g);
                    end
                end
            end
            checks++;
            if ({n_groups, err, sv} !== {exp_ng, exp_err, 32'd0}) begin
                errors++;
                $display("FAIL rand%0d_final got ng=%0d err=%0b stall_viol=%0d required %0d %0b 0",
                         it, n_groups, err, sv, exp_ng, exp_err);
            end
        end
    endtask

    initial begin
        c1[0] = '{d: 8'd5, l: 1'b0, g: 4'd0};
        c1[1] = '{d: 8'd7, l: 1'b1, g: 4'd0};
        c1[2] = '{d: 8'd9, l: 1'b1, g: 4'd1};
        clear_ram();
        test_reset();
        test_basic();
        test_empty();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_cs_ignored();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
